// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: program counter hookup, instruction memory read
// port, decode-side instruction handoff and the misaligned-fetch flag.
// The master side is the fetch unit; the slave side is everything around it.
interface fetch_unit_if;
  // Program counter hookup and redirect.
  logic [31:0] pc_addr;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_addr;

  // Instruction memory read port.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Decode handoff.
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // Status.
  logic        fetch_err;

  modport master (
    input  pc_addr, redirect, redirect_addr, imem_rvalid, imem_rdata, instr_ready,
    output pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
  );

  modport slave (
    output pc_addr, redirect, redirect_addr, imem_rvalid, imem_rdata, instr_ready,
    input  pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues one instruction memory read at a time from
// the current program counter, buffers returned words with their fetch
// address in a small FIFO for decode, and handles redirects by flushing the
// buffer and discarding any response still in flight.
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fu
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // WAIT: one read outstanding whose data will be kept.
  // DROP: one read outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e              state_q;
  logic [31:0]         req_pc_q;
  logic                fetch_err_q;

  entry_t              buf_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q,  count_d;

  logic                has_room;
  logic                aligned;
  logic                issue;
  logic                misaligned;
  logic                push;
  logic                pop;

  assign has_room = (count_q < CNT_W'(FIFO_DEPTH));
  assign aligned  = (fu.pc_addr[1:0] == 2'b00);

  // NOTE: rst_n gates the request combinationally so imem_req drops the
  // instant reset asserts, while still allowing the first request on the very
  // first clock after reset is released.
  assign issue      = rst_n && (state_q == IDLE) && !fu.redirect && has_room && aligned;
  assign misaligned = (state_q == IDLE) && !fu.redirect && !aligned;

  // Responses only enter the buffer when the request is still wanted; a
  // redirect in the same cycle kills both the push and any decode pop.
  assign push = (state_q == WAIT) && fu.imem_rvalid && !fu.redirect;
  assign pop  = (count_q != '0) && fu.instr_ready && !fu.redirect;

  // Program counter steering and memory request outputs.
  always_comb begin
    if (fu.redirect) begin
      fu.pc_next = fu.redirect_addr;
    end else if (issue) begin
      fu.pc_next = fu.pc_addr + 32'd4;
    end else begin
      fu.pc_next = fu.pc_addr;
    end
  end

  assign fu.imem_req  = issue;
  assign fu.imem_addr = fu.pc_addr;

  // Request/response sequencing and the sticky misaligned flag.
  // NOTE: every register here is updated with <=, so all of them see the
  // pre-edge values of each other regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_pc_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (fu.redirect) begin
        fetch_err_q <= 1'b0;
      end else if (misaligned) begin
        fetch_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // Any stray imem_rvalid here belongs to nobody and is ignored.
          if (issue) begin
            state_q  <= WAIT;
            req_pc_q <= fu.pc_addr;
          end
        end
        WAIT: begin
          // Response with a redirect is simply not pushed; either way the
          // read has completed.
          if (fu.imem_rvalid) begin
            state_q <= IDLE;
          end else if (fu.redirect) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          // Further redirects keep us here until the stale data shows up.
          if (fu.imem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer pointer and occupancy next-state; redirect flushes everything.
  // NOTE: each _d gets its hold value first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fu.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage; entries are written only on an accepted response.
  // NOTE: the storage is reset because instr/instr_pc are read straight from
  // the head entry and must be zero during reset; at this depth it is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[wr_ptr_q] <= '{pc: req_pc_q, word: fu.imem_rdata};
    end
  end

  assign fu.instr_valid = (count_q != '0);
  assign fu.instr       = buf_q[rd_ptr_q].word;
  assign fu.instr_pc    = buf_q[rd_ptr_q].pc;
  assign fu.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the program counter register and a
// fixed-latency instruction memory, and checks hand-computed expectations.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  fetch_unit_if fu ();

  fetch_unit #(.FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fu   (fu)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory model state.
  int          lat      = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Observation logs.
  logic [31:0] req_addr_q [$];
  int          req_cyc_q  [$];
  logic [31:0] pop_pc_q   [$];
  logic [31:0] pop_data_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
  endtask

  // One clock: sample DUT outputs before the edge, then update PC and memory.
  task automatic tick();
    logic        req;
    logic [31:0] addr, pcn, ppc, pdat;
    logic        popd;
    logic        rst_seen;
    #1;
    req      = fu.imem_req;
    addr     = fu.imem_addr;
    pcn      = fu.pc_next;
    popd     = fu.instr_valid && fu.instr_ready && !fu.redirect;
    ppc      = fu.instr_pc;
    pdat     = fu.instr;
    rst_seen = rst_n;
    @(posedge clk);
    #1;
    if (req) begin
      req_addr_q.push_back(addr);
      req_cyc_q.push_back(cyc);
    end
    if (popd) begin
      pop_pc_q.push_back(ppc);
      pop_data_q.push_back(pdat);
    end
    cyc++;
    fu.pc_addr     = rst_seen ? pcn : 32'h0;
    fu.imem_rvalid = 1'b0;
    if (req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = addr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        fu.imem_rvalid = 1'b1;
        fu.imem_rdata  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end
    end
    #1;
  endtask

  // Reset across one edge, release mid-cycle; memory model is cleared.
  task automatic do_reset();
    rst_n          = 1'b0;
    fu.redirect    = 1'b0;
    fu.pc_addr     = 32'h0;
    fu.imem_rvalid = 1'b0;
    mem_busy       = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    cyc = 0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    fu.pc_addr       = 32'h0;
    fu.redirect      = 1'b0;
    fu.redirect_addr = 32'h0;
    fu.imem_rvalid   = 1'b0;
    fu.imem_rdata    = 32'h0;
    fu.instr_ready   = 1'b1;
    #2;
    check("rst_instr_valid", {31'b0, fu.instr_valid}, 32'h0);
    check("rst_imem_req",    {31'b0, fu.imem_req},    32'h0);
    check("rst_fetch_err",   {31'b0, fu.fetch_err},   32'h0);
    check("rst_instr",       fu.instr,                32'h0);
    check("rst_instr_pc",    fu.instr_pc,             32'h0);

    // Streaming with a 1-cycle memory and decode always ready.
    fu.instr_ready = 1'b1;
    lat = 1;
    do_reset();
    check("first_req",      {31'b0, fu.imem_req}, 32'h1);
    check("first_req_addr", fu.imem_addr,         32'h0);
    repeat (7) tick();
    check("stream_nreq",   32'(req_addr_q.size()), 32'd4);
    check("stream_req0",   req_addr_q[0], 32'h0);
    check("stream_req1",   req_addr_q[1], 32'h4);
    check("stream_req2",   req_addr_q[2], 32'h8);
    check("stream_gap",    32'(req_cyc_q[1] - req_cyc_q[0]), 32'd2);
    check("stream_npop",   32'(pop_pc_q.size()), 32'd3);
    check("stream_pc0",    pop_pc_q[0],   32'h0);
    check("stream_pc1",    pop_pc_q[1],   32'h4);
    check("stream_pc2",    pop_pc_q[2],   32'h8);
    check("stream_data2",  pop_data_q[2], 32'hC0DE_0008);

    // Decode stalled: buffer fills at two entries and fetch stops.
    fu.instr_ready = 1'b0;
    lat = 1;
    do_reset();
    repeat (6) tick();
    check("stall_nreq",     32'(req_addr_q.size()), 32'd2);
    check("stall_req",      {31'b0, fu.imem_req}, 32'h0);
    check("stall_pc_next",  fu.pc_next,           32'h8);
    check("stall_head_pc",  fu.instr_pc,          32'h0);
    check("stall_head",     fu.instr,             32'hC0DE_0000);
    clear_logs();
    fu.instr_ready = 1'b1;
    tick();
    fu.instr_ready = 1'b0;
    #1;
    check("unstall_noreq",  32'(req_addr_q.size()), 32'd0);
    check("unstall_req",    {31'b0, fu.imem_req}, 32'h1);
    check("unstall_addr",   fu.imem_addr,         32'h8);
    check("unstall_head",   fu.instr_pc,          32'h4);

    // Redirect while a 3-cycle read is outstanding.
    fu.instr_ready = 1'b0;
    lat = 1;
    do_reset();
    tick();
    tick();
    lat = 3;
    tick();
    check("redir_pre_valid", {31'b0, fu.instr_valid}, 32'h1);
    fu.redirect      = 1'b1;
    fu.redirect_addr = 32'h100;
    #1;
    check("redir_pc_next",  fu.pc_next,           32'h100);
    check("redir_noreq",    {31'b0, fu.imem_req}, 32'h0);
    tick();
    fu.redirect = 1'b0;
    #1;
    check("redir_flushed",  {31'b0, fu.instr_valid}, 32'h0);
    check("drop_noreq0",    {31'b0, fu.imem_req},    32'h0);
    tick();
    check("drop_late_rv",   {31'b0, fu.imem_rvalid}, 32'h1);
    check("drop_noreq1",    {31'b0, fu.imem_req},    32'h0);
    tick();
    check("drop_discard",   {31'b0, fu.instr_valid}, 32'h0);
    check("redir_req",      {31'b0, fu.imem_req},    32'h1);
    check("redir_req_addr", fu.imem_addr,            32'h100);

    // Redirect coincident with a response and a pop; then with a full buffer.
    fu.instr_ready = 1'b0;
    lat = 1;
    do_reset();
    repeat (3) tick();
    check("coinc_rvalid",  {31'b0, fu.imem_rvalid}, 32'h1);
    fu.instr_ready   = 1'b1;
    fu.redirect      = 1'b1;
    fu.redirect_addr = 32'h40;
    #1;
    check("coinc_head",    fu.instr_pc, 32'h0);
    tick();
    fu.redirect    = 1'b0;
    fu.instr_ready = 1'b0;
    #1;
    check("coinc_empty",   {31'b0, fu.instr_valid}, 32'h0);
    check("coinc_req_addr", fu.imem_addr,           32'h40);
    tick();
    tick();
    check("coinc_push_pc",   fu.instr_pc, 32'h40);
    check("coinc_push_data", fu.instr,    32'hC0DE_0040);
    tick();
    tick();
    check("full_noreq",    {31'b0, fu.imem_req}, 32'h0);
    fu.instr_ready   = 1'b1;
    fu.redirect      = 1'b1;
    fu.redirect_addr = 32'h80;
    tick();
    fu.redirect    = 1'b0;
    fu.instr_ready = 1'b0;
    #1;
    check("full_flush",    {31'b0, fu.instr_valid}, 32'h0);
    check("full_req_addr", fu.imem_addr,            32'h80);

    // Misaligned fetch raises a sticky error until the next redirect.
    fu.instr_ready = 1'b1;
    lat = 1;
    do_reset();
    fu.redirect      = 1'b1;
    fu.redirect_addr = 32'h102;
    #1;
    check("mis_redir_noreq", {31'b0, fu.imem_req}, 32'h0);
    tick();
    fu.redirect = 1'b0;
    #1;
    check("mis_noreq",     {31'b0, fu.imem_req},  32'h0);
    check("mis_err_early", {31'b0, fu.fetch_err}, 32'h0);
    check("mis_pc_hold",   fu.pc_next,            32'h102);
    tick();
    check("mis_err_set",   {31'b0, fu.fetch_err}, 32'h1);
    repeat (3) tick();
    check("mis_err_held",  {31'b0, fu.fetch_err}, 32'h1);
    check("mis_noreq2",    {31'b0, fu.imem_req},  32'h0);
    fu.redirect      = 1'b1;
    fu.redirect_addr = 32'h200;
    #1;
    check("mis_err_redir", {31'b0, fu.fetch_err}, 32'h1);
    tick();
    fu.redirect = 1'b0;
    #1;
    check("mis_err_clr",   {31'b0, fu.fetch_err}, 32'h0);
    check("mis_req",       {31'b0, fu.imem_req},  32'h1);
    check("mis_req_addr",  fu.imem_addr,          32'h200);

    // Reset pulsed mid-read; the stale response lands in IDLE.
    fu.instr_ready = 1'b0;
    lat = 1;
    do_reset();
    tick();
    tick();
    lat = 3;
    tick();
    check("mrst_pre_valid", {31'b0, fu.instr_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_valid",    {31'b0, fu.instr_valid}, 32'h0);
    check("mrst_req",      {31'b0, fu.imem_req},    32'h0);
    check("mrst_instr",    fu.instr,                32'h0);
    check("mrst_instr_pc", fu.instr_pc,             32'h0);
    tick();
    tick();
    check("mrst_stale_rv", {31'b0, fu.imem_rvalid}, 32'h1);
    lat   = 1;
    rst_n = 1'b1;
    #1;
    check("mrst_first_req", {31'b0, fu.imem_req}, 32'h1);
    tick();
    check("mrst_stale_ign", {31'b0, fu.instr_valid}, 32'h0);
    tick();
    check("mrst_new_valid", {31'b0, fu.instr_valid}, 32'h1);
    check("mrst_new_pc",    fu.instr_pc,             32'h0);
    check("mrst_new_data",  fu.instr,                32'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
